bootrom_flash_loader: RTL and testbench

- Memory target that sits directly downstream of the boot ROM AXI bridge and serves its simple RAM interface (wr strobes / rd / addr / accept / read data).
- After reset it fills its internal word RAM by reading a boot image from an SPI NOR flash with command 0x03 (READ).
- It holds ram_accept_o low until the copy completes, then serves reads and writes at full rate.

---
 rtl/bootrom_flash_loader.sv | 150 +++++++++++++++
 tb/tb_bootrom_flash_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootrom_flash_loader.sv
// Boot RAM that copies an image from SPI NOR flash (READ 0x03) after reset,
// then serves the boot ROM bridge's simple RAM port at full rate.
module bootrom_flash_loader #(
    parameter int          MEM_WORDS  = 4096,
    parameter int          LOAD_WORDS = 4096,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          CLK_DIV    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  ram_wr_i,
    input  logic        ram_rd_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_write_data_i,
    output logic [31:0] ram_read_data_o,
    output logic        ram_accept_o,
    output logic        spi_clk_o,
    output logic        spi_cs_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        load_done_o
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0]   CMD_WORD  = {8'h03, FLASH_BASE};
    localparam logic [15:0]   DIV       = 16'(CLK_DIV);
    localparam logic [AW-1:0] LAST_WORD = AW'(LOAD_WORDS - 1);

    logic [31:0]   mem [MEM_WORDS];

    logic [1:0]    state;
    logic [15:0]   div_cnt;
    logic [4:0]    bit_cnt;
    logic [AW-1:0] word_cnt;
    logic [31:0]   cmd_sh;
    logic [31:0]   rx_sh;
    logic [31:0]   wr_word;
    logic          wr_pend;
    logic          hold;
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign idx          = ram_addr_i[AW+1:2];
    assign unused_addr  = ^{ram_addr_i[31:AW+2], ram_addr_i[1:0]};
    assign ram_accept_o = (state == S_DONE);
    assign load_done_o  = (state == S_DONE);

    // Freeze the SPI clock while the final word is being committed.
    assign hold = wr_pend && (word_cnt == LAST_WORD);

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            cmd_sh     <= '0;
            rx_sh      <= '0;
            wr_word    <= '0;
            wr_pend    <= 1'b0;
            spi_clk_o  <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_mosi_o <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    state      <= S_CMD;
                    spi_cs_o   <= 1'b0;
                    spi_mosi_o <= CMD_WORD[31];
                    cmd_sh     <= {CMD_WORD[30:0], 1'b0};
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    word_cnt   <= '0;
                end
                S_CMD, S_DATA: begin
                    if (!hold) begin
                        if (div_cnt == DIV) begin
                            div_cnt <= '0;
                            if (!spi_clk_o) begin
                                spi_clk_o <= 1'b1;
                                rx_sh     <= {rx_sh[30:0], spi_miso_i};
                            end else begin
                                spi_clk_o <= 1'b0;
                                bit_cnt   <= bit_cnt + 5'd1;
                                if (state == S_CMD) begin
                                    if (bit_cnt == 5'd31) begin
                                        state      <= S_DATA;
                                        spi_mosi_o <= 1'b0;
                                    end else begin
                                        spi_mosi_o <= cmd_sh[31];
                                        cmd_sh     <= {cmd_sh[30:0], 1'b0};
                                    end
                                end else if (bit_cnt == 5'd31) begin
                                    wr_pend <= 1'b1;
                                    wr_word <= byte_swap(rx_sh);
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 16'd1;
                        end
                    end
                end
                S_DONE: begin
                end
                default: state <= S_IDLE;
            endcase
            if (wr_pend) begin
                word_cnt <= word_cnt + 1'b1;
                if (word_cnt == LAST_WORD) begin
                    state     <= S_DONE;
                    spi_cs_o  <= 1'b1;
                    spi_clk_o <= 1'b0;
                end
            end
        end
    end

    // Loader writes only happen before DONE, so the port never collides.
    always_ff @(posedge clk_i) begin
        if (wr_pend) begin
            mem[word_cnt] <= wr_word;
        end else if (state == S_DONE) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_i[b]) begin
                    mem[idx][8*b +: 8] <= ram_write_data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_read_data_o <= '0;
        end else if (state == S_DONE && ram_rd_i) begin
            ram_read_data_o <= mem[idx];
        end
    end

endmodule

// File: tb/tb_bootrom_flash_loader.sv
// Directed bench: two loaders (CLK_DIV 0 and 3) against a behavioural
// SPI flash that streams bytes 0x00, 0x01, ... after the READ command.
module tb_bootrom_flash_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: CLK_DIV=0
    logic        rst0 = 1'b1;
    logic [3:0]  wr0 = '0;
    logic        rd0 = 1'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic [31:0] rdata0;
    logic        acc0, sck0, cs0, mosi0, miso0, done0;

    // Instance 1: CLK_DIV=3
    logic        rst1 = 1'b1;
    logic [3:0]  wr1 = '0;
    logic        rd1 = 1'b0;
    logic [31:0] addr1 = '0;
    logic [31:0] wdata1 = '0;
    logic [31:0] rdata1;
    logic        acc1, sck1, cs1, mosi1, miso1, done1;

    bootrom_flash_loader #(
        .MEM_WORDS(4096), .LOAD_WORDS(4), .FLASH_BASE(24'h000000), .CLK_DIV(0)
    ) u0 (
        .clk_i(clk), .rst_i(rst0), .ram_wr_i(wr0), .ram_rd_i(rd0),
        .ram_addr_i(addr0), .ram_write_data_i(wdata0),
        .ram_read_data_o(rdata0), .ram_accept_o(acc0),
        .spi_clk_o(sck0), .spi_cs_o(cs0), .spi_mosi_o(mosi0),
        .spi_miso_i(miso0), .load_done_o(done0)
    );

    bootrom_flash_loader #(
        .MEM_WORDS(4096), .LOAD_WORDS(4), .FLASH_BASE(24'h000000), .CLK_DIV(3)
    ) u1 (
        .clk_i(clk), .rst_i(rst1), .ram_wr_i(wr1), .ram_rd_i(rd1),
        .ram_addr_i(addr1), .ram_write_data_i(wdata1),
        .ram_read_data_o(rdata1), .ram_accept_o(acc1),
        .spi_clk_o(sck1), .spi_cs_o(cs1), .spi_mosi_o(mosi1),
        .spi_miso_i(miso1), .load_done_o(done1)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Flash data bit for a given count of completed SCK periods.
    function automatic logic fbit(input int nf);
        int d;
        logic [7:0] b;
        if (nf < 32) return 1'b0;
        d = nf - 32;
        b = 8'(d / 8);
        return b[7 - (d % 8)];
    endfunction

    int cyc0 = 0;
    int cyc1 = 0;
    always @(posedge clk) begin
        if (rst0) cyc0 = 0; else cyc0 = cyc0 + 1;
        if (rst1) cyc1 = 0; else cyc1 = cyc1 + 1;
    end

    // Flash model + monitors, instance 0
    int nf0 = 0, nr0 = 0, ncs0 = 0, early0 = 0, mosihi0 = 0, dcyc0 = -1;
    logic [31:0] cmd0 = '0;
    logic psck0 = 1'b0, pcs0 = 1'b1, seen0 = 1'b0;
    assign miso0 = fbit(nf0);

    always @(negedge clk) begin
        if (cs0 !== 1'b0) begin
            nf0 = 0;
            nr0 = 0;
        end else begin
            if (pcs0) ncs0++;
            if (psck0 && !sck0) nf0++;
            if (!psck0 && sck0 && nr0 < 32) begin
                cmd0 = {cmd0[30:0], mosi0};
                nr0++;
            end
            if (nf0 >= 32 && mosi0) mosihi0++;
        end
        psck0 = sck0;
        pcs0  = (cs0 !== 1'b0);
        if (!done0 && acc0) early0++;
        if (done0 === 1'b1 && !seen0) begin
            seen0 = 1'b1;
            dcyc0 = cyc0;
        end else if (done0 !== 1'b1) begin
            seen0 = 1'b0;
        end
    end

    // Flash model + phase monitor, instance 1
    int nf1 = 0, nr1 = 0, dcyc1 = -1, run1 = 0;
    int lmin1 = 1000, lmax1 = 0, hmin1 = 1000, hmax1 = 0;
    logic [31:0] cmd1 = '0;
    logic psck1 = 1'b0, act1 = 1'b0, seen1 = 1'b0;
    assign miso1 = fbit(nf1);

    always @(negedge clk) begin
        if (cs1 !== 1'b0) begin
            nf1  = 0;
            nr1  = 0;
            act1 = 1'b0;
        end else begin
            if (!act1) begin
                act1 = 1'b1;
                run1 = 1;
            end else if (sck1 == psck1) begin
                run1++;
            end else begin
                if (psck1) begin
                    if (run1 < hmin1) hmin1 = run1;
                    if (run1 > hmax1) hmax1 = run1;
                end else begin
                    if (run1 < lmin1) lmin1 = run1;
                    if (run1 > lmax1) lmax1 = run1;
                end
                run1 = 1;
            end
            if (psck1 && !sck1) nf1++;
            if (!psck1 && sck1 && nr1 < 32) begin
                cmd1 = {cmd1[30:0], mosi1};
                nr1++;
            end
        end
        psck1 = sck1;
        if (done1 === 1'b1 && !seen1) begin
            seen1 = 1'b1;
            dcyc1 = cyc1;
        end
    end

    task automatic rd_word(input bit u, input logic [31:0] a,
                           output logic [31:0] d);
        if (u) begin addr1 = a; rd1 = 1'b1; end
        else   begin addr0 = a; rd0 = 1'b1; end
        @(negedge clk);
        d = u ? rdata1 : rdata0;
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic wr_word0(input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        addr0  = a;
        wr0    = s;
        wdata0 = d;
        @(negedge clk);
        wr0 = '0;
    endtask

    logic [31:0] v, v2;
    int t;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_accept", {31'b0, acc0}, 32'h0);
        chk("rst_sck", {31'b0, sck0}, 32'h0);
        chk("rst_cs", {31'b0, cs0}, 32'h1);
        chk("rst_mosi", {31'b0, mosi0}, 32'h0);
        chk("rst_done", {31'b0, done0}, 32'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Read request held through the whole load
        addr0 = 32'h4;
        rd0   = 1'b1;
        t = 0;
        while (done0 !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        #1;
        chk("load_done_seen", {31'b0, done0}, 32'h1);
        chk("done_cycle_323pm1", {31'b0, (dcyc0 >= 322 && dcyc0 <= 324)}, 32'h1);
        chk("accept_in_done", {31'b0, acc0}, 32'h1);
        chk("accept_early", early0, 0);
        chk("cmd_mosi", cmd0, 32'h03000000);
        chk("mosi_in_data", mosihi0, 0);
        @(negedge clk);
        chk("first_read_4", rdata0, 32'h07060504);
        rd0 = 1'b0;

        rd_word(0, 32'h0, v);
        chk("mem0", v, 32'h03020100);
        rd_word(0, 32'hC, v);
        chk("mem3", v, 32'h0F0E0D0C);

        wr_word0(32'h8, 4'b0101, 32'hAABBCCDD);
        rd_word(0, 32'h8, v);
        chk("byte_write", v, 32'h0BBB09DD);

        wr_word0(32'hC, 4'b0000, 32'hDEADBEEF);
        rd_word(0, 32'hC, v);
        chk("zero_strobe", v, 32'h0F0E0D0C);

        rd_word(0, 32'h4000, v);
        rd_word(0, 32'h0, v2);
        chk("wrap_4000", v, 32'h03020100);
        chk("wrap_0", v2, 32'h03020100);

        addr0  = 32'h0;
        rd0    = 1'b1;
        wr0    = 4'hF;
        wdata0 = 32'h12345678;
        @(negedge clk);
        wr0 = '0;
        chk("rbw_old", rdata0, 32'h03020100);
        @(negedge clk);
        rd0 = 1'b0;
        chk("rbw_new", rdata0, 32'h12345678);

        // Fresh load, then reset during DATA word 2
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        t = 0;
        while (nf0 < 32 + 64 + 5 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("reach_word2", {31'b0, (nf0 >= 101)}, 32'h1);
        rst0 = 1'b1;
        @(negedge clk);
        chk("midrst_cs", {31'b0, cs0}, 32'h1);
        chk("midrst_sck", {31'b0, sck0}, 32'h0);
        rst0 = 1'b0;
        t = 0;
        while (done0 !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        #1;
        chk("reload_done", {31'b0, done0}, 32'h1);
        chk("cs_sessions", ncs0, 3);
        chk("cmd_resent", cmd0, 32'h03000000);
        rd_word(0, 32'h0, v);
        chk("reload_mem0", v, 32'h03020100);
        rd_word(0, 32'h4, v);
        chk("reload_mem1", v, 32'h07060504);
        rd_word(0, 32'hC, v);
        chk("reload_mem3", v, 32'h0F0E0D0C);

        // Divided SPI clock instance
        t = 0;
        while (done1 !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        #1;
        chk("div3_done", {31'b0, done1}, 32'h1);
        chk("div3_cycle_1283pm1", {31'b0, (dcyc1 >= 1282 && dcyc1 <= 1284)}, 32'h1);
        chk("div3_low_min", lmin1, 4);
        chk("div3_low_max", lmax1, 4);
        chk("div3_high_min", hmin1, 4);
        chk("div3_high_max", hmax1, 4);
        chk("div3_cmd", cmd1, 32'h03000000);
        rd_word(1, 32'h0, v);
        chk("div3_mem0", v, 32'h03020100);
        rd_word(1, 32'hC, v);
        chk("div3_mem3", v, 32'h0F0E0D0C);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
